command_sequencer: RTL and testbench
====================================

Name: command_sequencer

Overview:
- Controller that owns the single-port command BRAM (256 x 4-bit, 1-cycle read latency).
- Sequences three operations on it:
  - Record: append the switch command on a save strobe.
  - Playback: read commands back in order, holding each for a programmable step time.
  - Clear: zero the whole memory.
- Sits between the debounced key/switch inputs and the BRAM. Drives the motion/display logic through play_cmd/play_valid.

Parameters:
ADDR_W, 8, BRAM address width; depth = 2**ADDR_W
DATA_W, 4, BRAM word width
CMD_W, 2, command width (stored in low bits, upper bits written 0)
STEP_CYCLES, 50000000, clk cycles each played command is held (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
cmd_in  in  CMD_W  command from switches
save_pulse  in  1  one-cycle strobe: record cmd_in
play_start  in  1  one-cycle strobe: start playback from address 0
stop  in  1  one-cycle strobe: abort playback
clear_req  in  1  one-cycle strobe: zero memory and count
mem_addr  out  ADDR_W  BRAM address
mem_wdata  out  DATA_W  BRAM write data
mem_wren  out  1  BRAM write enable
mem_rden  out  1  BRAM read enable
mem_q  in  DATA_W  BRAM read data, valid the cycle after rden
cmd_count  out  ADDR_W+1  number of stored commands (0..2**ADDR_W)
full  out  1  cmd_count == 2**ADDR_W
play_cmd  out  CMD_W  command being played
play_valid  out  1  playback active, play_cmd meaningful
play_index  out  ADDR_W  address of command being played
busy  out  1  state != IDLE
done  out  1  one-cycle pulse: playback or clear completed

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs go to 0, including cmd_count, play_cmd and play_index.
  - Reset mid-operation aborts that operation immediately. BRAM contents are not touched.
- Memory outputs: mem_wren and mem_rden are 0 except in the states below. mem_addr and mem_wdata are 0 when unused.
- States: IDLE, WRITE, RD_ISSUE, RD_WAIT, HOLD, CLEAR.
- IDLE:
  - Request priority: clear_req > play_start > save_pulse. Lower-priority simultaneous strobes are dropped.
  - save_pulse with full=1 is ignored.
  - play_start with cmd_count=0 gives a done pulse next cycle and stays in IDLE.
- WRITE (1 cycle):
  - cmd_in is captured on the save_pulse edge.
  - mem_addr=cmd_count[ADDR_W-1:0], mem_wdata={0,cmd}, mem_wren=1.
  - cmd_count increments at the end of the cycle, then back to IDLE.
  - Minimum spacing between accepted saves is 2 cycles; a save_pulse arriving while in WRITE is dropped.
- Playback:
  - play_start sets play_index=0 and enters RD_ISSUE.
  - RD_ISSUE (1 cycle): mem_addr=play_index, mem_rden=1.
  - RD_WAIT (1 cycle): on the ending edge, play_cmd<=mem_q[CMD_W-1:0], play_valid<=1, timer<=STEP_CYCLES-1.
  - HOLD: timer decrements each cycle. At timer=0:
    - If play_index==cmd_count-1: play_valid<=0, done pulse, go to IDLE.
    - Otherwise: play_index++ and go to RD_ISSUE.
  - play_valid stays 1 across inter-step fetches; play_cmd changes only at the end of RD_WAIT.
  - Period per command is STEP_CYCLES+2 cycles.
  - stop in RD_ISSUE/RD_WAIT/HOLD: next cycle IDLE, play_valid=0, play_cmd holds its last value, no done pulse.
  - save_pulse, clear_req and play_start are ignored during playback.
- CLEAR:
  - Write 0 to addresses 0..2**ADDR_W-1, one per cycle, mem_wren=1, for 2**ADDR_W cycles.
  - On the last write: cmd_count<=0, play_index<=0, done pulse next cycle, go to IDLE.
  - All strobes, including stop, are ignored during CLEAR.
- Widths:
  - Timer width is clog2(STEP_CYCLES)+1.
  - cmd_count saturates at 2**ADDR_W and never wraps.
  - Address arithmetic is modulo 2**ADDR_W.
- busy=1 in every state except IDLE.

Test Plan:
- Reset then idle: rst_n low mid-HOLD -> all outputs 0 asynchronously; after release cmd_count=0, busy=0.
- Record 3 (cmd_in=1,2,3, save_pulse 4 cycles apart) -> writes addr0=4'h1, addr1=4'h2, addr2=4'h3, one mem_wren cycle each; cmd_count=3.
- Playback, STEP_CYCLES=4, 3 stored:
  - play_cmd sequence 1,2,3, each step starting 6 cycles apart.
  - play_index 0,1,2.
  - done pulses 1 cycle after the last HOLD ends; play_valid drops with it.
- stop during second HOLD -> IDLE next cycle, play_valid=0, play_cmd stays 2, done never asserts; play_start restarts at index 0.
- Fill to 256 saves -> full=1, cmd_count=256; 257th save_pulse produces no mem_wren; play_start with count 0 after a clear -> immediate done, no mem_rden.
- clear_req with simultaneous save_pulse -> save dropped; 256 consecutive zero writes on addr 0..255; cmd_count=0; done once; stop mid-clear ignored.

Source files
------------

// File: rtl/command_sequencer.sv
// Owns the single-port command BRAM: records switch commands, plays them back
// with a programmable hold time per step, and clears the whole memory.
module command_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 4,
  parameter int CMD_W       = 2,
  parameter int STEP_CYCLES = 50000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CMD_W-1:0]  cmd_in,
  input  logic              save_pulse,
  input  logic              play_start,
  input  logic              stop,
  input  logic              clear_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  output logic              mem_rden,
  input  logic [DATA_W-1:0] mem_q,
  output logic [ADDR_W:0]   cmd_count,
  output logic              full,
  output logic [CMD_W-1:0]  play_cmd,
  output logic              play_valid,
  output logic [ADDR_W-1:0] play_index,
  output logic              busy,
  output logic              done
);

  localparam int                 TIMER_W    = $clog2(STEP_CYCLES) + 1;
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(STEP_CYCLES - 1);
  localparam logic [ADDR_W:0]    DEPTH      = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_ISSUE,
    RD_WAIT,
    HOLD,
    CLEAR
  } state_t;

  state_t              state_q;
  logic [ADDR_W:0]     cmd_count_q;
  logic [CMD_W-1:0]    play_cmd_q;
  logic                play_valid_q;
  logic [ADDR_W-1:0]   play_index_q;
  logic [ADDR_W-1:0]   play_index_d;
  logic [TIMER_W-1:0]  timer_q;
  logic                done_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [ADDR_W-1:0]   clr_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                mem_wren_q;
  logic                mem_rden_q;
  logic                full_w;
  logic                last_step;

  assign full_w       = (cmd_count_q == DEPTH);
  assign play_index_d = play_index_q + 1'b1;
  assign clr_addr_d   = mem_addr_q + 1'b1;
  assign last_step    = ({1'b0, play_index_q} == (cmd_count_q - 1'b1));

  // Only the command bits of a stored word are meaningful on readback.
  if (DATA_W > CMD_W) begin : g_unused_hi
    logic unused_hi;
    assign unused_hi = ^mem_q[DATA_W-1:CMD_W];
  end

  // Memory strobes are registered on entry to their state, so they line up
  // with state_q; by default they return to 0 every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cmd_count_q  <= '0;
      play_cmd_q   <= '0;
      play_valid_q <= 1'b0;
      play_index_q <= '0;
      timer_q      <= '0;
      done_q       <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wren_q   <= 1'b0;
      mem_rden_q   <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      mem_wren_q  <= 1'b0;
      mem_rden_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      case (state_q)
        IDLE: begin
          if (clear_req) begin
            state_q    <= CLEAR;
            mem_wren_q <= 1'b1;
          end else if (play_start) begin
            if (cmd_count_q == '0) begin
              done_q <= 1'b1;
            end else begin
              play_index_q <= '0;
              mem_rden_q   <= 1'b1;
              state_q      <= RD_ISSUE;
            end
          end else if (save_pulse && !full_w) begin
            mem_addr_q  <= cmd_count_q[ADDR_W-1:0];
            mem_wdata_q <= DATA_W'(cmd_in);
            mem_wren_q  <= 1'b1;
            state_q     <= WRITE;
          end
        end
        WRITE: begin
          if (cmd_count_q != DEPTH) cmd_count_q <= cmd_count_q + 1'b1;
          state_q <= IDLE;
        end
        RD_ISSUE: begin
          if (stop) begin
            play_valid_q <= 1'b0;
            state_q      <= IDLE;
          end else begin
            state_q <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (stop) begin
            play_valid_q <= 1'b0;
            state_q      <= IDLE;
          end else begin
            play_cmd_q   <= mem_q[CMD_W-1:0];
            play_valid_q <= 1'b1;
            timer_q      <= TIMER_LOAD;
            state_q      <= HOLD;
          end
        end
        HOLD: begin
          if (stop) begin
            play_valid_q <= 1'b0;
            state_q      <= IDLE;
          end else if (timer_q != '0) begin
            timer_q <= timer_q - 1'b1;
          end else if (last_step) begin
            play_valid_q <= 1'b0;
            done_q       <= 1'b1;
            state_q      <= IDLE;
          end else begin
            play_index_q <= play_index_d;
            mem_addr_q   <= play_index_d;
            mem_rden_q   <= 1'b1;
            state_q      <= RD_ISSUE;
          end
        end
        CLEAR: begin
          // mem_addr_q doubles as the sweep counter for the zero fill.
          if (mem_addr_q == '1) begin
            cmd_count_q  <= '0;
            play_index_q <= '0;
            done_q       <= 1'b1;
            state_q      <= IDLE;
          end else begin
            mem_addr_q <= clr_addr_d;
            mem_wren_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wren   = mem_wren_q;
  assign mem_rden   = mem_rden_q;
  assign cmd_count  = cmd_count_q;
  assign full       = full_w;
  assign play_cmd   = play_cmd_q;
  assign play_valid = play_valid_q;
  assign play_index = play_index_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;

endmodule

// File: tb/tb_command_sequencer.sv
// Bench for command_sequencer: directed stimulus feeds expectation queues,
// a negedge monitor pops and compares whenever the DUT writes, plays or finishes.
module tb_command_sequencer;

  localparam int STEP = 4;

  logic       clk;
  logic       rst_n;
  logic [1:0] cmd_in;
  logic       save_pulse, play_start, stop, clear_req;
  logic [7:0] mem_addr;
  logic [3:0] mem_wdata;
  logic       mem_wren, mem_rden;
  logic [3:0] mem_q;
  logic [8:0] cmd_count;
  logic       full;
  logic [1:0] play_cmd;
  logic       play_valid;
  logic [7:0] play_index;
  logic       busy, done;

  command_sequencer #(
    .ADDR_W(8), .DATA_W(4), .CMD_W(2), .STEP_CYCLES(STEP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_in(cmd_in), .save_pulse(save_pulse),
    .play_start(play_start), .stop(stop), .clear_req(clear_req),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
    .mem_rden(mem_rden), .mem_q(mem_q), .cmd_count(cmd_count), .full(full),
    .play_cmd(play_cmd), .play_valid(play_valid), .play_index(play_index),
    .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural 256x4 BRAM with one-cycle read latency.
  logic [3:0] ram [256];
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 4'h0;
    mem_q = 4'h0;
  end
  always @(posedge clk) begin
    if (mem_wren) ram[mem_addr] <= mem_wdata;
    if (mem_rden) mem_q <= ram[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int addr; int data; } wr_t;
  typedef struct { int idx; int cmd; int gap; } step_t;
  wr_t   wr_q[$];
  step_t step_q[$];
  int    done_exp = 0;
  int    n_cmp = 0;
  int    n_fail = 0;
  int    rd_cnt = 0;
  int    last_step_cyc = 0;
  int    last_done_cyc = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor
  logic       prev_valid = 1'b0;
  logic [7:0] prev_index = 8'd0;
  bit         pend = 1'b0;
  int         pend_cyc = 0;

  task automatic record_step();
    step_t e;
    if (step_q.size() == 0) begin
      check("unexpected_step", 1, 0);
    end else begin
      e = step_q.pop_front();
      check("step_index", play_index, e.idx);
      check("step_cmd", play_cmd, e.cmd);
      if (e.gap != 0) check("step_gap", cyc - last_step_cyc, e.gap);
    end
    last_step_cyc = cyc;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      pend       = 1'b0;
    end else begin
      if (mem_wren) begin
        if (wr_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          check("wr_addr", mem_addr, w.addr);
          check("wr_data", mem_wdata, w.data);
        end
      end
      if (mem_rden) rd_cnt++;
      if (done) begin
        if (done_exp == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          done_exp--;
          check("done_valid_low", play_valid, 0);
        end
        last_done_cyc = cyc;
      end
      if (!play_valid) begin
        pend = 1'b0;
      end else if (!prev_valid) begin
        record_step();
      end else if (play_index != prev_index) begin
        pend     = 1'b1;
        pend_cyc = cyc + 2;
      end
      if (pend && play_valid && cyc == pend_cyc) begin
        record_step();
        pend = 1'b0;
      end
      prev_valid = play_valid;
      prev_index = play_index;
    end
  end

  // Stimulus
  task automatic pulse(input bit s, input bit p, input bit t, input bit c, input logic [1:0] cmd);
    @(posedge clk); #1;
    save_pulse = s; play_start = p; stop = t; clear_req = c; cmd_in = cmd;
    @(posedge clk); #1;
    save_pulse = 1'b0; play_start = 1'b0; stop = 1'b0; clear_req = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget && done_exp > 0; k++) @(posedge clk);
    #1;
    check("done_seen", done_exp, 0);
  endtask

  task automatic push_step(input int idx, input int cmd, input int gap);
    step_t e;
    e.idx = idx; e.cmd = cmd; e.gap = gap;
    step_q.push_back(e);
  endtask

  task automatic push_wr(input int addr, input int data);
    wr_t w;
    w.addr = addr; w.data = data;
    wr_q.push_back(w);
  endtask

  task automatic play_three();
    int rd0;
    rd0 = rd_cnt;
    push_step(0, 1, 0);
    push_step(1, 2, STEP + 2);
    push_step(2, 3, STEP + 2);
    done_exp = 1;
    pulse(0, 1, 0, 0, 2'd0);
    wait_done(80);
    check("play_reads", rd_cnt - rd0, 3);
    check("done_after_hold", last_done_cyc - last_step_cyc, STEP);
    check("play_idle_busy", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; cmd_in = 2'd0;
    save_pulse = 1'b0; play_start = 1'b0; stop = 1'b0; clear_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_count", cmd_count, 0);
    check("rst_wren", mem_wren, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_count", cmd_count, 0);
    check("idle_full", full, 0);
    check("idle_valid", play_valid, 0);

    // Record 1,2,3
    for (int i = 1; i <= 3; i++) begin
      push_wr(i - 1, i);
      pulse(1, 0, 0, 0, 2'(i));
      repeat (2) @(posedge clk);
    end
    @(posedge clk); #1;
    check("rec_count", cmd_count, 3);

    play_three();

    // Stop during the second HOLD, then restart from index 0
    push_step(0, 1, 0);
    push_step(1, 2, STEP + 2);
    pulse(0, 1, 0, 0, 2'd0);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (play_valid && play_cmd == 2'd2) break;
    end
    pulse(0, 0, 1, 0, 2'd0);
    check("stop_valid", play_valid, 0);
    check("stop_cmd_hold", play_cmd, 2);
    check("stop_busy", busy, 0);
    repeat (10) @(posedge clk);
    #1;
    check("stop_steps_left", step_q.size(), 0);
    play_three();

    // Clear with a simultaneous save; strobes mid-clear are ignored
    for (int i = 0; i < 256; i++) push_wr(i, 0);
    done_exp = 1;
    pulse(1, 0, 0, 1, 2'd3);
    repeat (50) @(posedge clk);
    pulse(1, 1, 1, 0, 2'd2);
    check("clear_busy_mid", busy, 1);
    wait_done(400);
    check("clear_count", cmd_count, 0);
    check("clear_writes_left", wr_q.size(), 0);

    // Fill to capacity, then one extra save
    for (int i = 0; i < 256; i++) begin
      push_wr(i, (i + 1) % 4);
      pulse(1, 0, 0, 0, 2'((i + 1) % 4));
    end
    @(posedge clk); #1;
    check("fill_count", cmd_count, 256);
    check("fill_full", full, 1);
    pulse(1, 0, 0, 0, 2'd1);
    repeat (3) @(posedge clk);
    #1;
    check("overfill_count", cmd_count, 256);
    check("overfill_writes_left", wr_q.size(), 0);

    // Asynchronous reset in the middle of HOLD
    push_step(0, 1, 0);
    pulse(0, 1, 0, 0, 2'd0);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (play_valid) break;
    end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", play_valid, 0);
    check("arst_cmd", play_cmd, 0);
    check("arst_index", play_index, 0);
    check("arst_count", cmd_count, 0);
    check("arst_busy", busy, 0);
    check("arst_full", full, 0);
    check("arst_mem", {mem_wren, mem_rden, mem_addr, mem_wdata}, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_count", cmd_count, 0);
    check("post_rst_busy", busy, 0);

    // Plain clear, then play_start with nothing stored
    for (int i = 0; i < 256; i++) push_wr(i, 0);
    done_exp = 1;
    pulse(0, 0, 0, 1, 2'd0);
    wait_done(400);
    begin
      int rd0;
      rd0 = rd_cnt;
      done_exp = 1;
      pulse(0, 1, 0, 0, 2'd0);
      repeat (3) @(posedge clk);
      #1;
      check("empty_done", done_exp, 0);
      check("empty_reads", rd_cnt - rd0, 0);
      check("empty_busy", busy, 0);
    end

    repeat (5) @(posedge clk);
    #1;
    check("end_writes_left", wr_q.size(), 0);
    check("end_steps_left", step_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
